aes_decrypt_core: RTL and testbench
===================================

Name: aes_decrypt_core

Overview:
Iterative AES-128 inverse cipher (FIPS-197) that pairs with AES_top.
- Takes a 128-bit ciphertext and the same 128-bit cipher key the encryptor uses.
- Runs a forward key expansion to reach round key 10, then undoes each round with an on-the-fly inverse key schedule.
- Returns the plaintext with a one-cycle valid pulse.
- Uses the same AES_en / AES_data_in / AES_key_in handshake as the encrypt path, so one bench can drive both.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a compile-time error.

Ports:
- AES_clk  input  1  clock; all state updates on the rising edge.
- AES_rst_n  input  1  asynchronous active-low reset.
- AES_en  input  1  start request; a 0->1 transition starts one decryption.
- AES_data_in  input  128  ciphertext, bit 127 = byte 0 (FIPS column-major).
- AES_key_in  input  128  cipher key (round key 0), same byte ordering.
- AES_data_out  output  128  plaintext; held until the next completion.
- AES_data_out_valid  output  1  one-cycle pulse when AES_data_out updates.
- AES_busy  output  1  high from the capture cycle through the final round.

Behaviour:
- Reset: AES_data_out = 0, AES_data_out_valid = 0, AES_busy = 0, FSM = IDLE, en_d = 0, state/key/round registers = 0. Reset is async assert, sync release, and takes effect at any point mid-operation.
- Edge detect: en_d <= AES_en every cycle. start = AES_en & ~en_d & (FSM == IDLE).
  - Holding AES_en high never retriggers.
  - A rising edge while busy is dropped, not queued.
  - AES_en falling mid-run has no effect.
- Data and key inputs are sampled only in the start cycle (cycle 0). Changes afterwards are ignored.
- States: IDLE -> KEYEXP -> INIT -> ROUND -> FINAL -> IDLE.
  - IDLE, on start: st <= AES_data_in, rk <= AES_key_in, rcon <= 0x01, rnd <= 1. Next state KEYEXP.
  - KEYEXP, cycles 1..10: rk <= forward expansion (RotWord, SubWord, rcon). rcon <= xtime(rcon), giving 0x01..0x36. rnd++. After rnd 10, next state INIT.
  - INIT, cycle 11: st <= st ^ rk10. rk <= inverse expansion (rk9). rcon <= inv_xtime(rcon). rnd <= 9.
  - ROUND, cycles 12..20: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk). rk steps back one round. rnd--. When rnd == 1 the next state is FINAL.
  - FINAL, cycle 21: result = InvSubBytes(InvShiftRows(st)) ^ rk0.
  - Cycle 22: AES_data_out <= result, AES_data_out_valid = 1 for exactly one cycle, AES_busy = 0, FSM = IDLE.
- Latency: capture edge to valid = 22 cycles. The next start is accepted from the valid cycle onward; a rising edge in that cycle starts a new run.
- Inverse key step: w3' = w3^w2, w2' = w2^w1, w1' = w1^w0, w0' = w0 ^ SubWord(RotWord(w3')) ^ {rcon,0,0,0}.
- S-box and inverse S-box are computed as GF(2^8) inverse (poly 0x11B, inv(0) = 0) plus the affine / inverse affine transform. Lookup ROMs are not used.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN.
- When defined:
  - Registers cached_key and cached_rk10 plus a cache_valid flag; cache_valid is cleared by reset.
  - On start with AES_key_in == cached_key and cache_valid = 1, the core loads rk <= cached_rk10, skips KEYEXP and goes straight to INIT the next cycle. Latency becomes 12 cycles.
  - A miss behaves as the base design and refreshes the cache at the end of KEYEXP.
- When undefined: no cache registers exist and latency is always 22 cycles.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734, valid 22 cycles after capture. Internal rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 10.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff.
- AES_en held high 51 cycles, data/key changed at cycles 5 and 30 -> exactly one valid pulse, output from the cycle-0 inputs only.
- Rising edge on AES_en at cycle 8 of a run (en low, then high again) -> ignored; a single valid pulse at cycle 22.
- AES_rst_n pulled low at cycle 15 -> all outputs 0 immediately. The next start after release gives a correct result at the full 22-cycle latency.
- AES_DEC_KEY_CACHE_EN defined: two back-to-back App. B decryptions -> first valid at 22 cycles, second at 12 cycles, both correct. Third run with the C.1 key -> 22 cycles.

Source files
------------

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then rounds undone with an on-the-fly inverse key schedule.
// Optional AES_DEC_KEY_CACHE_EN keeps the last key/rk10 pair so a repeated key skips the expansion.
module aes_decrypt_core #(
  parameter int unsigned NR = 10
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  if (NR != 10) begin : g_nr_check
    $error("aes_decrypt_core: only NR=10 (AES-128) is supported");
  end

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL} state_t;

  state_t       r_state;
  logic         r_en_d;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_cached_key;
  logic [127:0] r_cached_rk10;
  logic         r_cache_valid;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? {1'b1, a[7:1] ^ 7'h0d} : {1'b0, a[7:1]};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 by repeated squaring; yields 0 for a == 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq, r;
    sq = a;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic         w_start;
  logic [7:0]   w_rcon_back;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [31:0]  w_b0, w_b1, w_b2, w_b3;
  logic [127:0] w_rk_fwd, w_rk_back, w_isb;

  assign w_start     = AES_en & ~r_en_d & (r_state == S_IDLE);
  // r_rcon runs one step ahead after KEYEXP, so the backward step always uses inv_xtime of it
  assign w_rcon_back = inv_xtime(r_rcon);

  assign w_f0     = r_rk[127:96] ^ sub_rot_word(r_rk[31:0]) ^ {r_rcon, 24'h0};
  assign w_f1     = r_rk[95:64] ^ w_f0;
  assign w_f2     = r_rk[63:32] ^ w_f1;
  assign w_f3     = r_rk[31:0]  ^ w_f2;
  assign w_rk_fwd = {w_f0, w_f1, w_f2, w_f3};

  assign w_b3      = r_rk[31:0]  ^ r_rk[63:32];
  assign w_b2      = r_rk[63:32] ^ r_rk[95:64];
  assign w_b1      = r_rk[95:64] ^ r_rk[127:96];
  assign w_b0      = r_rk[127:96] ^ sub_rot_word(w_b3) ^ {w_rcon_back, 24'h0};
  assign w_rk_back = {w_b0, w_b1, w_b2, w_b3};

  assign w_isb = inv_sr_sb(r_st);

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_state            <= S_IDLE;
      r_en_d             <= 1'b0;
      r_st               <= '0;
      r_rk               <= '0;
      r_rcon             <= '0;
      r_rnd              <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
      AES_busy           <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      r_cached_key       <= '0;
      r_cached_rk10      <= '0;
      r_cache_valid      <= 1'b0;
`endif
    end else begin
      r_en_d             <= AES_en;
      AES_data_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_st     <= AES_data_in;
            r_rnd    <= 4'd1;
            AES_busy <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (r_cache_valid && (AES_key_in == r_cached_key)) begin
              r_rk    <= r_cached_rk10;
              r_rcon  <= 8'h6c;
              r_state <= S_INIT;
            end else begin
              r_rk          <= AES_key_in;
              r_rcon        <= 8'h01;
              r_state       <= S_KEYEXP;
              r_cached_key  <= AES_key_in;
              r_cache_valid <= 1'b0;
            end
`else
            r_rk    <= AES_key_in;
            r_rcon  <= 8'h01;
            r_state <= S_KEYEXP;
`endif
          end
        end
        S_KEYEXP: begin
          r_rk   <= w_rk_fwd;
          r_rcon <= xtime(r_rcon);
          r_rnd  <= r_rnd + 4'd1;
          if (r_rnd == 4'(NR)) begin
            r_state <= S_INIT;
`ifdef AES_DEC_KEY_CACHE_EN
            r_cached_rk10 <= w_rk_fwd;
            r_cache_valid <= 1'b1;
`endif
          end
        end
        S_INIT: begin
          r_st    <= r_st ^ r_rk;
          r_rk    <= w_rk_back;
          r_rcon  <= w_rcon_back;
          r_rnd   <= 4'(NR - 1);
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_st   <= inv_mix(w_isb ^ r_rk);
          r_rk   <= w_rk_back;
          r_rcon <= w_rcon_back;
          r_rnd  <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) r_state <= S_FINAL;
        end
        S_FINAL: begin
          // FINAL spans two cycles: r_rnd==0 computes the result into r_st, then it is published
          if (r_rnd == 4'd0) begin
            r_st  <= w_isb ^ r_rk;
            r_rnd <= 4'd1;
          end else begin
            AES_data_out       <= r_st;
            AES_data_out_valid <= 1'b1;
            AES_busy           <= 1'b0;
            r_rnd              <= 4'd0;
            r_state            <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core using FIPS-197 App. B and C.1 vectors.
module tb_aes_decrypt_core;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 12;
`else
  localparam int HIT_LAT = 22;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic [127:0] data_out;
  logic         valid;
  logic         busy;

  int n_checks = 0;
  int n_fail = 0;

  aes_decrypt_core #(.NR(10)) dut (
    .AES_clk            (clk),
    .AES_rst_n          (rst_n),
    .AES_en             (en),
    .AES_data_in        (data_in),
    .AES_key_in         (key_in),
    .AES_data_out       (data_out),
    .AES_data_out_valid (valid),
    .AES_busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench 1ns after the capture edge (cycle 0)
  task automatic start(input logic [127:0] k, input logic [127:0] d);
    en = 1'b0;
    tick();
    key_in  = k;
    data_in = d;
    en      = 1'b1;
    tick();
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (valid) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, pulses;
    logic [127:0] dout;

    #22;
    chk("reset_data", data_out, '0);
    chk("reset_valid", 128'(valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    tick();

    // App. B with internal rk10 check
    start(KB, CB);
    chk("b_busy_cap", 128'(busy), 128'd1);
    en = 1'b0;
    repeat (10) tick();
    chk("b_rk10", dut.r_rk, RK10B);
    lat = -1;
    for (int n = 11; n <= 40; n++) begin
      tick();
      if (valid) begin
        lat = n;
        break;
      end
    end
    chk("b_lat", 128'(lat), 128'd22);
    chk("b_data", data_out, PB);
    chk("b_busy_done", 128'(busy), 128'd0);
    tick();
    chk("b_pulse_width", 128'(valid), 128'd0);

    // App. C.1
    start(KC, CC);
    en = 1'b0;
    wait_valid(lat);
    chk("c1_lat", 128'(lat), 128'd22);
    chk("c1_data", data_out, PC);

    // AES_en held 51 cycles, inputs changed mid-run
    start(KB, CB);
    pulses = 0;
    lat = -1;
    dout = '0;
    for (int c = 1; c <= 50; c++) begin
      if (c == 5) begin
        key_in  = KC;
        data_in = CC;
      end
      if (c == 30) begin
        key_in  = 128'hdeadbeef_00000000_12345678_9abcdef0;
        data_in = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      end
      tick();
      if (valid) begin
        pulses++;
        if (lat < 0) begin
          lat  = c;
          dout = data_out;
        end
      end
    end
    en = 1'b0;
    chk("hold_pulses", 128'(pulses), 128'd1);
    chk("hold_lat", 128'(lat), 128'd22);
    chk("hold_data", dout, PB);

    // rising edge while busy is dropped
    start(KC, CC);
    en = 1'b0;
    pulses = 0;
    lat = -1;
    dout = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 8) begin
        en      = 1'b1;
        key_in  = KB;
        data_in = CB;
      end
      tick();
      if (valid) begin
        pulses++;
        if (lat < 0) begin
          lat  = c;
          dout = data_out;
        end
      end
    end
    en = 1'b0;
    chk("edge8_pulses", 128'(pulses), 128'd1);
    chk("edge8_lat", 128'(lat), 128'd22);
    chk("edge8_data", dout, PC);

    // async reset mid-run
    start(KB, CB);
    en = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", data_out, '0);
    chk("rst_mid_valid", 128'(valid), 128'd0);
    chk("rst_mid_busy", 128'(busy), 128'd0);
    #10;
    rst_n = 1'b1;
    tick();
    start(KC, CC);
    en = 1'b0;
    wait_valid(lat);
    chk("post_rst_lat", 128'(lat), 128'd22);
    chk("post_rst_data", data_out, PC);

    // back-to-back same key (cache hit when enabled), then a different key
    start(KB, CB);
    en = 1'b0;
    wait_valid(lat);
    chk("b2b1_lat", 128'(lat), 128'd22);
    chk("b2b1_data", data_out, PB);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_valid(lat2);
    chk("b2b2_lat", 128'(lat2), 128'(HIT_LAT));
    chk("b2b2_data", data_out, PB);
    start(KC, CC);
    en = 1'b0;
    wait_valid(lat);
    chk("b2b3_lat", 128'(lat), 128'd22);
    chk("b2b3_data", data_out, PC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
